// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: widths, reset constants and the PC source selector.
// Also used by instrmem and the decoder so every stage agrees on word and address sizes.
package fetch_unit_pkg;

    localparam int ADDR_WIDTH  = 12;
    localparam int INSTR_WIDTH = 16;

    typedef logic [ADDR_WIDTH-1:0]  addr_t;
    typedef logic [INSTR_WIDTH-1:0] instr_t;

    localparam addr_t  RESET_PC  = 12'h000;
    localparam instr_t NOP_INSTR = 16'h0000;

    typedef enum logic [1:0] {
        PC_SEQ,
        PC_LOOP,
        PC_BRANCH,
        PC_HOLD
    } pc_sel_e;

    // Program memory is a ring: 12'hFFF rolls over to 12'h000.
    function automatic addr_t pc_inc(input addr_t pc);
        return pc + addr_t'(1);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction-memory bus between the fetch stage (master) and instrmem (slave).
// The read is combinational: imem_instr belongs to imem_addr in the same cycle.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    addr_t  imem_addr;
    instr_t imem_instr;

    modport master (output imem_addr, input imem_instr);
    modport slave  (input imem_addr, output imem_instr);

endinterface

// File: rtl/fetch_unit_loop_ctrl.sv
// Single-level zero-overhead loop controller: holds the loop bounds and iteration
// count and tells the PC mux when the current fetch must jump back to the loop start.
module fetch_unit_loop_ctrl
    import fetch_unit_pkg::*;
(
    input  logic  clk,
    input  logic  reset,
    input  addr_t pc,
    input  logic  advance,
    input  logic  loop_start,
    input  addr_t loop_begin,
    input  addr_t loop_end,
    input  addr_t loop_count,
    output logic  loop_active,
    output logic  take_loop,
    output addr_t loop_target
);

    addr_t begin_q;
    addr_t end_q;
    addr_t count_q;
    logic  active_q;
    logic  at_end;

    assign at_end      = active_q && (pc == end_q);
    assign take_loop   = at_end && (count_q > addr_t'(1));
    assign loop_target = begin_q;
    assign loop_active = active_q;

    // The old loop decision is applied first so a same-cycle re-arm overwrites it.
    always_ff @(posedge clk) begin
        if (reset) begin
            begin_q  <= '0;
            end_q    <= '0;
            count_q  <= '0;
            active_q <= 1'b0;
        end else begin
            if (advance && at_end) begin
                if (take_loop) begin
                    count_q <= count_q - addr_t'(1);
                end else begin
                    count_q  <= '0;
                    active_q <= 1'b0;
                end
            end
            if (loop_start && (loop_count != '0)) begin
                begin_q  <= loop_begin;
                end_q    <= loop_end;
                count_q  <= loop_count;
                active_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives instrmem and registers the fetched
// word into the IF/ID register, with stall, branch flush and hardware-loop support.
module fetch_unit
    import fetch_unit_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   stall,
    input  logic   branch_en,
    input  addr_t  branch_target,
    input  logic   loop_start,
    input  addr_t  loop_begin,
    input  addr_t  loop_end,
    input  addr_t  loop_count,
    fetch_unit_if.master imem,
    output instr_t if_instr,
    output addr_t  if_pc,
    output logic   if_valid,
    output logic   loop_active
);

    addr_t   pc_q;
    addr_t   pc_next;
    addr_t   loop_target;
    pc_sel_e pc_sel;
    logic    take_loop;
    logic    advance;

    assign imem.imem_addr = pc_q;

    fetch_unit_loop_ctrl u_loop_ctrl (
        .clk         (clk),
        .reset       (reset),
        .pc          (pc_q),
        .advance     (advance),
        .loop_start  (loop_start),
        .loop_begin  (loop_begin),
        .loop_end    (loop_end),
        .loop_count  (loop_count),
        .loop_active (loop_active),
        .take_loop   (take_loop),
        .loop_target (loop_target)
    );

    // A branch wins even over stall so a redirect is never lost behind a hazard.
    always_comb begin
        pc_sel = PC_SEQ;
        if (branch_en) begin
            pc_sel = PC_BRANCH;
        end else if (stall) begin
            pc_sel = PC_HOLD;
        end else if (take_loop) begin
            pc_sel = PC_LOOP;
        end
    end

    assign advance = (pc_sel == PC_SEQ) || (pc_sel == PC_LOOP);

    always_comb begin
        pc_next = pc_inc(pc_q);
        case (pc_sel)
            PC_BRANCH: pc_next = branch_target;
            PC_HOLD:   pc_next = pc_q;
            PC_LOOP:   pc_next = loop_target;
            default:   pc_next = pc_inc(pc_q);
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            if_instr <= NOP_INSTR;
            if_pc    <= '0;
            if_valid <= 1'b0;
        end else begin
            pc_q <= pc_next;
            if (pc_sel == PC_BRANCH) begin
                if_instr <= NOP_INSTR;
                if_valid <= 1'b0;
            end else if (advance) begin
                if_instr <= imem.imem_instr;
                if_pc    <= pc_q;
                if_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a combinational instrmem model: reset, stall,
// branch flush, hardware loop, PC wrap, ignored zero-count loop and mid-loop reset.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    logic   clk;
    logic   reset;
    logic   stall;
    logic   branch_en;
    addr_t  branch_target;
    logic   loop_start;
    addr_t  loop_begin;
    addr_t  loop_end;
    addr_t  loop_count;
    instr_t if_instr;
    addr_t  if_pc;
    logic   if_valid;
    logic   loop_active;

    instr_t mem [0:4095];
    int     assert_count;
    int     fail_count;
    int     loop_seq [9];

    fetch_unit_if imem_bus ();

    assign imem_bus.imem_instr = mem[imem_bus.imem_addr];

    fetch_unit dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_en     (branch_en),
        .branch_target (branch_target),
        .loop_start    (loop_start),
        .loop_begin    (loop_begin),
        .loop_end      (loop_end),
        .loop_count    (loop_count),
        .imem          (imem_bus.master),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_valid      (if_valid),
        .loop_active   (loop_active)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected)
        else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    initial begin
        assert_count  = 0;
        fail_count    = 0;
        loop_seq      = '{5, 6, 4, 5, 6, 4, 5, 6, 7};
        for (int i = 0; i < 4096; i++) mem[i] = 16'hA000 ^ 16'(i);
        mem[0] = 16'h0509;
        mem[2] = 16'h0101;

        reset = 1'b1; stall = 1'b0; branch_en = 1'b0; branch_target = '0;
        loop_start = 1'b0; loop_begin = '0; loop_end = '0; loop_count = '0;

        // Reset and sequential fetch
        applyStimulus(2);
        checkOutput("rst_addr", 32'(imem_bus.imem_addr), 32'h0);
        checkOutput("rst_valid", 32'(if_valid), 32'h0);
        checkOutput("rst_instr", 32'(if_instr), 32'h0);
        checkOutput("rst_loop", 32'(loop_active), 32'h0);
        reset = 1'b0;
        applyStimulus(1);
        checkOutput("c1_addr", 32'(imem_bus.imem_addr), 32'h1);
        checkOutput("c1_instr", 32'(if_instr), 32'h0509);
        checkOutput("c1_pc", 32'(if_pc), 32'h0);
        checkOutput("c1_valid", 32'(if_valid), 32'h1);
        applyStimulus(2);
        checkOutput("c3_instr", 32'(if_instr), 32'h0101);
        checkOutput("c3_pc", 32'(if_pc), 32'h2);
        applyStimulus(2);
        checkOutput("pre_stall_addr", 32'(imem_bus.imem_addr), 32'h5);

        // Stall holds PC and IF/ID
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1);
            checkOutput("stall_addr", 32'(imem_bus.imem_addr), 32'h5);
            checkOutput("stall_pc", 32'(if_pc), 32'h4);
            checkOutput("stall_instr", 32'(if_instr), 32'hA004);
        end
        stall = 1'b0;
        applyStimulus(1);
        checkOutput("resume_addr", 32'(imem_bus.imem_addr), 32'h6);
        checkOutput("resume_pc", 32'(if_pc), 32'h5);
        applyStimulus(1);
        checkOutput("pre_br_addr", 32'(imem_bus.imem_addr), 32'h7);

        // Branch flush, then branch together with stall
        branch_en = 1'b1; branch_target = 12'h020;
        applyStimulus(1);
        branch_en = 1'b0;
        checkOutput("br_addr", 32'(imem_bus.imem_addr), 32'h020);
        checkOutput("br_valid", 32'(if_valid), 32'h0);
        checkOutput("br_instr", 32'(if_instr), 32'h0);
        applyStimulus(1);
        checkOutput("br_next_pc", 32'(if_pc), 32'h020);
        checkOutput("br_next_valid", 32'(if_valid), 32'h1);
        checkOutput("br_next_instr", 32'(if_instr), 32'hA020);
        branch_en = 1'b1; stall = 1'b1;
        applyStimulus(1);
        branch_en = 1'b0; stall = 1'b0;
        checkOutput("brst_addr", 32'(imem_bus.imem_addr), 32'h020);
        checkOutput("brst_valid", 32'(if_valid), 32'h0);
        checkOutput("brst_instr", 32'(if_instr), 32'h0);
        applyStimulus(1);
        checkOutput("brst_next_pc", 32'(if_pc), 32'h020);
        checkOutput("brst_next_valid", 32'(if_valid), 32'h1);

        // Hardware loop 4..6, three iterations
        branch_en = 1'b1; branch_target = 12'h004;
        loop_start = 1'b1; loop_begin = 12'h004; loop_end = 12'h006; loop_count = 12'h003;
        applyStimulus(1);
        branch_en = 1'b0; loop_start = 1'b0;
        checkOutput("loop_arm_addr", 32'(imem_bus.imem_addr), 32'h4);
        checkOutput("loop_arm_active", 32'(loop_active), 32'h1);
        for (int i = 0; i < 9; i++) begin
            applyStimulus(1);
            checkOutput("loop_addr", 32'(imem_bus.imem_addr), 32'(loop_seq[i]));
            checkOutput("loop_if_pc", 32'(if_pc), (i == 0) ? 32'h4 : 32'(loop_seq[i-1]));
            checkOutput("loop_active", 32'(loop_active), (i < 8) ? 32'h1 : 32'h0);
        end

        // PC wrap and zero-count loop request
        branch_en = 1'b1; branch_target = 12'hFFF;
        applyStimulus(1);
        branch_en = 1'b0;
        checkOutput("wrap_pre_addr", 32'(imem_bus.imem_addr), 32'hFFF);
        loop_start = 1'b1; loop_begin = 12'h001; loop_end = 12'h002; loop_count = 12'h000;
        applyStimulus(1);
        loop_start = 1'b0;
        checkOutput("wrap_addr", 32'(imem_bus.imem_addr), 32'h000);
        checkOutput("wrap_if_pc", 32'(if_pc), 32'hFFF);
        checkOutput("wrap_instr", 32'(if_instr), 32'hAFFF);
        checkOutput("zero_cnt_active", 32'(loop_active), 32'h0);
        applyStimulus(3);
        checkOutput("zero_cnt_addr", 32'(imem_bus.imem_addr), 32'h3);
        checkOutput("zero_cnt_active2", 32'(loop_active), 32'h0);

        // Reset in the middle of a loop (second pass, pc=5, count=2)
        branch_en = 1'b1; branch_target = 12'h004;
        loop_start = 1'b1; loop_begin = 12'h004; loop_end = 12'h006; loop_count = 12'h003;
        applyStimulus(1);
        branch_en = 1'b0; loop_start = 1'b0;
        applyStimulus(4);
        checkOutput("midloop_addr", 32'(imem_bus.imem_addr), 32'h5);
        checkOutput("midloop_active", 32'(loop_active), 32'h1);
        reset = 1'b1;
        applyStimulus(1);
        reset = 1'b0;
        checkOutput("mrst_addr", 32'(imem_bus.imem_addr), 32'h0);
        checkOutput("mrst_active", 32'(loop_active), 32'h0);
        checkOutput("mrst_valid", 32'(if_valid), 32'h0);
        checkOutput("mrst_instr", 32'(if_instr), 32'h0);
        applyStimulus(1);
        checkOutput("mrst_next_addr", 32'(imem_bus.imem_addr), 32'h1);
        checkOutput("mrst_next_instr", 32'(if_instr), 32'h0509);

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
